// File: rtl/execute_if.sv
// Execute-stage port bundle between the control unit (master) and the execute unit (slave).
interface execute_if #(parameter int WIDTH = 32);
  logic             start;
  logic [3:0]       aluOp;
  logic [WIDTH-1:0] regA;
  logic [WIDTH-1:0] regB;
  logic [4:0]       shamt;
  logic [4:0]       regDIn;
  logic             busy;
  logic             done;
  logic             regWrite;
  logic [4:0]       regD;
  logic [WIDTH-1:0] writeData;
  logic             zero;
  logic             overflow;

  modport master (
    output start, aluOp, regA, regB, shamt, regDIn,
    input  busy, done, regWrite, regD, writeData, zero, overflow
  );

  modport slave (
    input  start, aluOp, regA, regB, shamt, regDIn,
    output busy, done, regWrite, regD, writeData, zero, overflow
  );
endinterface

// File: rtl/execute_unit.sv
// Execute stage: single-cycle ALU/shift ops plus an iterative shift-add multiplier
// and restoring divider sharing one set of working registers.
module execute_unit #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      reset,
  execute_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOR = 4'd5;
  localparam logic [3:0] OP_SLT = 4'd6;
  localparam logic [3:0] OP_SLL = 4'd7;
  localparam logic [3:0] OP_SRL = 4'd8;
  localparam logic [3:0] OP_SRA = 4'd9;
  localparam logic [3:0] OP_MUL = 4'd10;
  localparam logic [3:0] OP_DIV = 4'd11;
  localparam logic [3:0] OP_REM = 4'd12;

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Operation captured at the accepting edge; the engine works only from these.
  logic [3:0]       op_p1;
  logic [4:0]       regD_p1;
  logic [WIDTH-1:0] acc_p1;
  logic [WIDTH-1:0] opA_p1;
  logic [WIDTH-1:0] opB_p1;

  logic [WIDTH-1:0] aluRes;
  logic             aluOvf;
  logic             accept;
  logic             isMulti;
  logic             lastStep;
  logic [WIDTH-1:0] mulAcc;
  logic [WIDTH:0]   remShift;
  logic [WIDTH:0]   remDiff;
  logic [WIDTH-1:0] divRem;
  logic [WIDTH-1:0] divQuot;
  logic [WIDTH-1:0] iterResult;

  function automatic logic [WIDTH-1:0] aluResult(
    input logic [3:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [4:0]       sh
  );
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic [WIDTH-1:0]        r;
    sa = a;
    sb = b;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      OP_SLT:  r = (sa < sb) ? WIDTH'(1) : '0;
      OP_SLL:  r = b << sh;
      OP_SRL:  r = b >> sh;
      OP_SRA:  r = sb >>> sh;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic addSubOverflow(
    input logic [3:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [WIDTH-1:0] r
  );
    logic ovf;
    case (op)
      OP_ADD:  ovf = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      OP_SUB:  ovf = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      default: ovf = 1'b0;
    endcase
    return ovf;
  endfunction

  always_comb begin
    accept   = bus.start && (state != ITER);
    isMulti  = bus.aluOp inside {OP_MUL, OP_DIV, OP_REM};
    aluRes   = aluResult(bus.aluOp, bus.regA, bus.regB, bus.shamt);
    aluOvf   = addSubOverflow(bus.aluOp, bus.regA, bus.regB, aluRes);
    lastStep = (cnt == LAST);

    // MUL: opA is the shifting multiplicand, opB the shifting multiplier.
    mulAcc   = acc_p1 + (opB_p1[0] ? opA_p1 : '0);

    // DIV/REM: acc is the partial remainder, opA shifts dividend bits out and quotient bits in.
    // A zero divisor never fails the trial subtract, giving all-ones quotient and remainder=dividend.
    remShift = {acc_p1, opA_p1[WIDTH-1]};
    remDiff  = remShift - {1'b0, opB_p1};
    if (remDiff[WIDTH]) begin
      divRem  = remShift[WIDTH-1:0];
      divQuot = {opA_p1[WIDTH-2:0], 1'b0};
    end else begin
      divRem  = remDiff[WIDTH-1:0];
      divQuot = {opA_p1[WIDTH-2:0], 1'b1};
    end

    if (op_p1 == OP_MUL)      iterResult = mulAcc;
    else if (op_p1 == OP_DIV) iterResult = divQuot;
    else                      iterResult = divRem;
  end

  assign bus.busy = (state == ITER);

  // Stage p1: operand capture and one engine step per ITER cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p1   <= bus.aluOp;
      regD_p1 <= bus.regDIn;
      acc_p1  <= '0;
      opA_p1  <= bus.regA;
      opB_p1  <= bus.regB;
    end else if (state == ITER) begin
      if (op_p1 == OP_MUL) begin
        acc_p1 <= mulAcc;
        opA_p1 <= opA_p1 << 1;
        opB_p1 <= opB_p1 >> 1;
      end else begin
        acc_p1 <= divRem;
        opA_p1 <= divQuot;
      end
    end
  end

  // Stage p2: registered results and control FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      bus.done      <= 1'b0;
      bus.regWrite  <= 1'b0;
      bus.regD      <= '0;
      bus.writeData <= '0;
      bus.zero      <= 1'b0;
      bus.overflow  <= 1'b0;
    end else begin
      case (state)
        ITER: begin
          cnt <= cnt + CNT_W'(1);
          if (lastStep) begin
            state         <= DONE;
            bus.done      <= 1'b1;
            bus.regWrite  <= (regD_p1 != '0);
            bus.regD      <= regD_p1;
            bus.writeData <= iterResult;
            bus.zero      <= (iterResult == '0);
            bus.overflow  <= 1'b0;
          end
        end
        default: begin
          if (bus.start) begin
            if (isMulti) begin
              state        <= ITER;
              cnt          <= '0;
              bus.done     <= 1'b0;
              bus.regWrite <= 1'b0;
            end else begin
              state         <= DONE;
              bus.done      <= 1'b1;
              bus.regWrite  <= (bus.aluOp <= OP_REM) && (bus.regDIn != '0);
              bus.regD      <= bus.regDIn;
              bus.writeData <= aluRes;
              bus.zero      <= (aluRes == '0);
              bus.overflow  <= aluOvf;
            end
          end else begin
            state        <= IDLE;
            bus.done     <= 1'b0;
            bus.regWrite <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_execute_unit.sv
// Bench for execute_unit: directed vector table, hand-written multi-cycle sequences,
// and randomized ops checked against an arithmetic reference model.
module tb_execute_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  execute_if #(.WIDTH(W)) bus();
  execute_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [4:0]  rd;
    logic [31:0] expData;
    logic        expOvf;
    logic        expZero;
    logic        expWr;
    int          expLat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic on the architectural definition of each op.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic [4:0] rd,
                       output logic [31:0] d, output logic ovf, output logic wr, output int lat);
    longint sa, sb, s;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    s   = 0;
    ovf = 1'b0;
    case (op)
      4'd0: begin s = sa + sb; d = s[31:0]; end
      4'd1: begin s = sa - sb; d = s[31:0]; end
      4'd2: d = a & b;
      4'd3: d = a | b;
      4'd4: d = a ^ b;
      4'd5: d = ~(a | b);
      4'd6: d = (sa < sb) ? 32'd1 : 32'd0;
      4'd7: d = b << sh;
      4'd8: d = b >> sh;
      4'd9: begin s = sb >>> sh; d = s[31:0]; end
      4'd10: begin p = {32'd0, a} * {32'd0, b}; d = p[31:0]; end
      4'd11: d = (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd12: d = (b == 0) ? a : a % b;
      default: d = 32'd0;
    endcase
    if (op <= 4'd1)
      ovf = (s > longint'(32'h7FFF_FFFF)) || (s < -longint'(32'h8000_0000));
    wr  = (op <= 4'd12) && (rd != 5'd0);
    lat = (op >= 4'd10 && op <= 4'd12) ? 33 : 1;
  endtask

  // Issue one op, scramble inputs after acceptance, wait (bounded) for done.
  task automatic runOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic [4:0] rd,
                       output int lat, output int busyCnt);
    @(negedge clk);
    bus.start = 1'b1; bus.aluOp = op; bus.regA = a; bus.regB = b; bus.shamt = sh; bus.regDIn = rd;
    @(negedge clk);
    bus.start = 1'b0; bus.aluOp = 4'($urandom); bus.regA = $urandom; bus.regB = $urandom;
    bus.shamt = 5'($urandom); bus.regDIn = 5'($urandom);
    lat = 1;
    busyCnt = 0;
    while (bus.done !== 1'b1 && lat < 60) begin
      if (bus.busy) busyCnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic checkOp(input string name, input logic [31:0] d, input logic ovf, input logic zero,
                         input logic wr, input logic [4:0] rd, input int expLat,
                         input int lat, input int busyCnt);
    chk({name, " latency"}, lat, expLat);
    chk({name, " busyCycles"}, busyCnt, (expLat > 1) ? 32 : 0);
    chk({name, " writeData"}, bus.writeData, d);
    chk({name, " regWrite"}, {31'd0, bus.regWrite}, {31'd0, wr});
    chk({name, " regD"}, {27'd0, bus.regD}, {27'd0, rd});
    chk({name, " zero"}, {31'd0, bus.zero}, {31'd0, zero});
    chk({name, " overflow"}, {31'd0, bus.overflow}, {31'd0, ovf});
  endtask

  task automatic chkAllZero(input string name);
    chk({name, " done"}, {31'd0, bus.done}, 32'd0);
    chk({name, " busy"}, {31'd0, bus.busy}, 32'd0);
    chk({name, " regWrite"}, {31'd0, bus.regWrite}, 32'd0);
    chk({name, " writeData"}, bus.writeData, 32'd0);
    chk({name, " regD"}, {27'd0, bus.regD}, 32'd0);
    chk({name, " zero"}, {31'd0, bus.zero}, 32'd0);
    chk({name, " overflow"}, {31'd0, bus.overflow}, 32'd0);
  endtask

  initial begin
    int lat, busyCnt, doneCnt;
    logic [31:0] d, seenData;
    logic [4:0]  seenRd;
    logic ovf, wr;
    logic [3:0] op;
    logic [31:0] a, b;
    logic [4:0] sh, rd;

    vecs.push_back('{4'd0,  32'd7,          32'd5,          5'd0,  5'd3,  32'd12,         1'b0, 1'b0, 1'b1, 1});
    vecs.push_back('{4'd0,  32'h7FFF_FFFF,  32'd1,          5'd0,  5'd4,  32'h8000_0000,  1'b1, 1'b0, 1'b1, 1});
    vecs.push_back('{4'd1,  32'd5,          32'd5,          5'd0,  5'd6,  32'd0,          1'b0, 1'b1, 1'b1, 1});
    vecs.push_back('{4'd6,  32'hFFFF_FFFF,  32'd2,          5'd0,  5'd8,  32'd1,          1'b0, 1'b0, 1'b1, 1});
    vecs.push_back('{4'd9,  32'd0,          32'h8000_0000,  5'd4,  5'd9,  32'hF800_0000,  1'b0, 1'b0, 1'b1, 1});
    vecs.push_back('{4'd10, 32'd1234,       32'd5678,       5'd0,  5'd10, 32'd7006652,    1'b0, 1'b0, 1'b1, 33});
    vecs.push_back('{4'd11, 32'd100,        32'd7,          5'd0,  5'd11, 32'd14,         1'b0, 1'b0, 1'b1, 33});
    vecs.push_back('{4'd12, 32'd100,        32'd7,          5'd0,  5'd12, 32'd2,          1'b0, 1'b0, 1'b1, 33});
    vecs.push_back('{4'd11, 32'd9,          32'd0,          5'd0,  5'd13, 32'hFFFF_FFFF,  1'b0, 1'b0, 1'b1, 33});
    vecs.push_back('{4'd12, 32'd9,          32'd0,          5'd0,  5'd14, 32'd9,          1'b0, 1'b0, 1'b1, 33});
    vecs.push_back('{4'd0,  32'd1,          32'd2,          5'd0,  5'd0,  32'd3,          1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{4'd14, 32'd5,          32'd6,          5'd0,  5'd15, 32'd0,          1'b0, 1'b1, 1'b0, 1});
    vecs.push_back('{4'd2,  32'hF0F0,       32'hFF00,       5'd0,  5'd16, 32'hF000,       1'b0, 1'b0, 1'b1, 1});
    vecs.push_back('{4'd3,  32'hF0F0,       32'hFF00,       5'd0,  5'd17, 32'hFFF0,       1'b0, 1'b0, 1'b1, 1});
    vecs.push_back('{4'd4,  32'hF0F0,       32'hFF00,       5'd0,  5'd18, 32'h0FF0,       1'b0, 1'b0, 1'b1, 1});
    vecs.push_back('{4'd5,  32'd0,          32'd0,          5'd0,  5'd19, 32'hFFFF_FFFF,  1'b0, 1'b0, 1'b1, 1});
    vecs.push_back('{4'd7,  32'd0,          32'd1,          5'd31, 5'd20, 32'h8000_0000,  1'b0, 1'b0, 1'b1, 1});
    vecs.push_back('{4'd8,  32'd0,          32'h8000_0000,  5'd4,  5'd21, 32'h0800_0000,  1'b0, 1'b0, 1'b1, 1});
    vecs.push_back('{4'd1,  32'h8000_0000,  32'd1,          5'd0,  5'd22, 32'h7FFF_FFFF,  1'b1, 1'b0, 1'b1, 1});
    vecs.push_back('{4'd6,  32'd2,          32'hFFFF_FFFF,  5'd0,  5'd23, 32'd0,          1'b0, 1'b1, 1'b1, 1});
    vecs.push_back('{4'd10, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd0,  5'd24, 32'd1,          1'b0, 1'b0, 1'b1, 33});

    reset = 1'b1;
    bus.start = 1'b0; bus.aluOp = 4'd0; bus.regA = '0; bus.regB = '0; bus.shamt = '0; bus.regDIn = '0;
    repeat (3) @(negedge clk);
    chkAllZero("reset");
    reset = 1'b0;

    foreach (vecs[i]) begin
      runOp(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh, vecs[i].rd, lat, busyCnt);
      checkOp($sformatf("vec%0d", i), vecs[i].expData, vecs[i].expOvf, vecs[i].expZero,
              vecs[i].expWr, vecs[i].rd, vecs[i].expLat, lat, busyCnt);
    end

    // Reset beats a simultaneous start.
    @(negedge clk);
    reset = 1'b1; bus.start = 1'b1; bus.aluOp = 4'd0; bus.regA = 32'd1; bus.regB = 32'd1; bus.regDIn = 5'd1;
    @(negedge clk);
    chkAllZero("resetVsStart");
    reset = 1'b0; bus.start = 1'b0;

    // A start pulse during the iteration is ignored: exactly one done.
    @(negedge clk);
    bus.start = 1'b1; bus.aluOp = 4'd10; bus.regA = 32'd1234; bus.regB = 32'd5678; bus.regDIn = 5'd7;
    @(negedge clk);
    bus.start = 1'b0;
    doneCnt = 0; seenData = '0; seenRd = '0;
    for (int i = 0; i < 45; i++) begin
      if (bus.done) begin
        doneCnt++;
        seenData = bus.writeData;
        seenRd = bus.regD;
      end
      if (i == 5) begin
        bus.start = 1'b1; bus.aluOp = 4'd0; bus.regA = 32'd1; bus.regB = 32'd1; bus.regDIn = 5'd9;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    chk("midStart doneCount", doneCnt, 1);
    chk("midStart writeData", seenData, 32'd7006652);
    chk("midStart regD", {27'd0, seenRd}, 32'd7);

    // Back-to-back: single-cycle ops keep done high, a MUL issued in DONE drops it.
    @(negedge clk);
    bus.start = 1'b1; bus.aluOp = 4'd0; bus.regA = 32'd1; bus.regB = 32'd2; bus.regDIn = 5'd1;
    @(negedge clk);
    chk("b2b first done", {31'd0, bus.done}, 32'd1);
    chk("b2b first data", bus.writeData, 32'd3);
    bus.aluOp = 4'd1; bus.regA = 32'd10; bus.regB = 32'd3; bus.regDIn = 5'd2;
    @(negedge clk);
    chk("b2b second done", {31'd0, bus.done}, 32'd1);
    chk("b2b second data", bus.writeData, 32'd7);
    chk("b2b second regD", {27'd0, bus.regD}, 32'd2);
    bus.aluOp = 4'd10; bus.regA = 32'd3; bus.regB = 32'd4; bus.regDIn = 5'd3;
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b mul done drop", {31'd0, bus.done}, 32'd0);
    chk("b2b mul busy", {31'd0, bus.busy}, 32'd1);
    lat = 1;
    while (bus.done !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b mul latency", lat, 33);
    chk("b2b mul data", bus.writeData, 32'd12);

    // Reset during iteration 10 aborts the multiply.
    @(negedge clk);
    bus.start = 1'b1; bus.aluOp = 4'd10; bus.regA = 32'd1234; bus.regB = 32'd5678; bus.regDIn = 5'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chkAllZero("abort");
    doneCnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done || bus.regWrite) doneCnt++;
      @(negedge clk);
    end
    chk("abort noDone", doneCnt, 0);
    runOp(4'd0, 32'd1, 32'd1, 5'd0, 5'd5, lat, busyCnt);
    checkOp("afterAbort add", 32'd2, 1'b0, 1'b0, 1'b1, 5'd5, 1, lat, busyCnt);

    // Randomized ops against the reference model.
    for (int n = 0; n < 120; n++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(8, 28);
      sh = 5'($urandom);
      rd = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom);
      model(op, a, b, sh, rd, d, ovf, wr, lat);
      begin
        int expLat;
        expLat = lat;
        runOp(op, a, b, sh, rd, lat, busyCnt);
        checkOp($sformatf("rand%0d op%0d", n, op), d, ovf, (d == 32'd0), wr, rd, expLat, lat, busyCnt);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/execute_unit.md
# execute_unit

Execute stage of the 32-bit datapath: consumes the two operands read from `registerBank` (`regA`, `regB`), computes an ALU, shift, multiply or divide result, and returns `writeData`/`regD`/`regWrite` to the bank's write port. Single-cycle ops take one cycle. MUL/DIV/REM use an iterative 32-step engine with a busy/done handshake toward the control unit.

## Interface
- `WIDTH`, 32, datapath width; multi-cycle ops iterate `WIDTH` steps.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  issue request; accepted only when `busy`=0.
- `aluOp`  in  4  operation code; see Operation.
- `regA`  in  WIDTH  operand A, rs value from `registerBank`.
- `regB`  in  WIDTH  operand B, rt value from `registerBank`.
- `shamt`  in  5  shift amount for SLL/SRL/SRA.
- `regDIn`  in  5  destination register index.
- `busy`  out  1  high while the iterative engine runs.
- `done`  out  1  one-cycle pulse; result valid.
- `regWrite`  out  1  write enable to `registerBank`; high only with `done`.
- `regD`  out  5  destination index, valid with `done`.
- `writeData`  out  WIDTH  result.
- `zero`  out  1  `writeData`==0, valid with `done`.
- `overflow`  out  1  signed overflow (ADD/SUB only), valid with `done`.

## Operation
- Ops:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLT: signed; result 1 or 0.
  - 7 SLL, 8 SRL, 9 SRA: shift `regB` by `shamt`.
  - 10 MUL: low WIDTH bits of the product.
  - 11 DIV: unsigned quotient.
  - 12 REM: unsigned remainder.
  - 13–15 illegal: `done` pulses, `writeData`=0, `regWrite`=0.
- All inputs are latched on the accepting edge. Later changes do not affect the result.
- FSM states: IDLE, ITER, DONE.
  - IDLE or DONE, `start`=1, single-cycle or illegal op → DONE.
  - IDLE or DONE, `start`=1, op 10–12 → ITER, counter=0.
  - ITER: one shift-add (MUL) or restoring-subtract (DIV/REM) step per cycle. Counter reaches WIDTH-1 → DONE.
  - DONE, `start`=0 → IDLE.
- `busy` = (state==ITER). `start` is ignored while `busy`=1.
- `regWrite` = `done` && legal op && `regD`≠0. Register 0 is never written.
- Divide by zero:
  - DIV → 0xFFFFFFFF.
  - REM → dividend.
  - `regWrite` follows the normal rule.
- `overflow` on ADD/SUB:
  - ADD: operand signs equal and result sign differs.
  - SUB: operand signs differ and result sign ≠ A's sign.
  - Result is still written. `overflow` is 0 for all other ops.
- MUL is unsigned shift-add. Low 32 bits are correct for signed operands as well.

## Timing
- Reset: all outputs 0, state IDLE, counter 0.
  - Reset mid-ITER aborts the operation: no `done`, no `regWrite`.
  - Reset wins over a simultaneous `start`.
- Single-cycle op accepted at edge t: `done`/`regWrite`/`writeData` are high/valid in cycle t+1, from registered outputs.
- Multi-cycle op accepted at edge t:
  - `busy`=1 for cycles t+1 … t+WIDTH.
  - `done` in cycle t+WIDTH+1, i.e. 33 cycles for WIDTH=32.
- Back-to-back: `start` during a DONE cycle is accepted.
  - Single-cycle ops sustain one result per cycle (`done` stays high).
  - A MUL issued in DONE drops `done` the next cycle.
- `writeData`, `regD`, `zero` and `overflow` hold their last values when `done`=0. The bank qualifies them only with `regWrite`.

## Test plan
- Reset, then ADD A=7, B=5, regDIn=3 → one cycle later: `done`=1, `regWrite`=1, `writeData`=12, `regD`=3, `zero`=0, `overflow`=0.
- ADD 0x7FFFFFFF+1 → `writeData`=0x80000000, `overflow`=1. SUB 5−5 → `zero`=1. SLT −1<2 → 1. SRA 0x80000000 by 4 → 0xF8000000.
- MUL 1234×5678 → `busy`=1 for exactly 32 cycles, then `done` on cycle 33 with 7006652. A `start` pulsed mid-op is ignored: exactly one `done`.
- DIV 100/7 → 14; REM 100/7 → 2. DIV 9/0 → 0xFFFFFFFF; REM 9/0 → 9.
- ADD with regDIn=0 → `done`=1, `regWrite`=0. aluOp=14 → `done`=1, `regWrite`=0, `writeData`=0.
- MUL started, `reset` asserted at iteration 10 → all outputs 0 next cycle, no `done`. A following ADD 1+1 completes normally with 2.
